// File: rtl/rand_server_pkg.sv
// ---------------------------------------------------------------------------
// rand_server_pkg
//   Shared types and constants for the random-byte server.
//   - fsm_e      : pool controller states (FILL refills, SERVE hands out bytes)
//   - POOL_BYTES : bytes carved out of one 32-bit generator snapshot
//   - COUNT_W    : width of the unread-byte counter (holds 0..POOL_BYTES)
//   - SHIFT_*    : xorshift32 shift triple (13, 17, 5)
// ---------------------------------------------------------------------------
package rand_server_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    SERVE = 1'b1
  } fsm_e;

  localparam int unsigned POOL_BYTES = 4;
  localparam int unsigned COUNT_W    = $clog2(POOL_BYTES + 1);

  localparam int unsigned SHIFT_A = 13;
  localparam int unsigned SHIFT_B = 17;
  localparam int unsigned SHIFT_C = 5;

endpackage : rand_server_pkg

// File: rtl/rand_server_xorshift32_step.sv
// ---------------------------------------------------------------------------
// xorshift32_step
//   One purely combinational xorshift32 iteration:
//     x ^= x << 13; x ^= x >> 17; x ^= x << 5;
//   Ports:
//     x_in  [31:0] : current generator value
//     x_out [31:0] : value after one step
// ---------------------------------------------------------------------------
module xorshift32_step
  import rand_server_pkg::*;
(
  input  logic [31:0] x_in,
  output logic [31:0] x_out
);

  logic [31:0] t_a;
  logic [31:0] t_b;

  assign t_a   = x_in ^ (x_in << SHIFT_A);
  assign t_b   = t_a  ^ (t_a  >> SHIFT_B);
  assign x_out = t_b  ^ (t_b  << SHIFT_C);

endmodule : xorshift32_step

// File: rtl/rand_server.sv
// ---------------------------------------------------------------------------
// rand_server
//   Serves random bytes to two requesters from a free-running xorshift32
//   generator. A 32-bit snapshot of the generator is taken into a byte pool
//   (FILL); bytes are then handed out one per grant, low byte first (SERVE).
//   When the last byte is handed out the controller refills on the next cycle.
//
//   Ports:
//     clk        : single clock, all state changes on its rising edge
//     reset      : synchronous, active-high
//     key_event  : user-input stir; generator takes two steps this cycle
//     req0/mask0 : CPU request, held until granted; AND-mask for its byte
//     req1/mask1 : auxiliary request, held until granted; AND-mask
//     gnt0/gnt1  : registered one-cycle grant pulses, never both high
//     rdata[7:0] : granted byte, valid while a grant is high, held otherwise
//
//   Parameter:
//     SEED       : nonzero generator value loaded at reset
// ---------------------------------------------------------------------------
module rand_server
  import rand_server_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd42
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       key_event,
  input  logic       req0,
  input  logic [7:0] mask0,
  input  logic       req1,
  input  logic [7:0] mask1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] rdata
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]        state_q, state_d;
  logic [31:0]        pool_q,  pool_d;
  logic [COUNT_W-1:0] count_q, count_d;
  fsm_e               fsm_q,   fsm_d;
  logic               gnt0_q,  gnt0_d;
  logic               gnt1_q,  gnt1_d;
  logic [7:0]         rdata_q, rdata_d;
  // Index of the port granted most recently (0 or 1).
  logic               last_q,  last_d;

  // -------------------------------------------------------------------------
  // Generator: two chained steps; key_event selects the second.
  // -------------------------------------------------------------------------
  logic [31:0] step_one;
  logic [31:0] step_two;

  xorshift32_step u_step_one (
    .x_in  (state_q),
    .x_out (step_one)
  );

  xorshift32_step u_step_two (
    .x_in  (step_one),
    .x_out (step_two)
  );

  // -------------------------------------------------------------------------
  // Arbitration
  // A port whose grant is showing this cycle still has its request high (the
  // requester only sees the grant at the end of the cycle), so it is masked
  // out to avoid serving the same request twice.
  // -------------------------------------------------------------------------
  logic elig0;
  logic elig1;
  logic pick1;

  assign elig0 = req0 & ~gnt0_q;
  assign elig1 = req1 & ~gnt1_q;
  // Port 1 wins when it is the only one asking, or when both ask and port 0
  // was served last.
  assign pick1 = elig1 & (~elig0 | ~last_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = key_event ? step_two : step_one;
    pool_d  = pool_q;
    count_d = count_q;
    fsm_d   = fsm_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rdata_d = rdata_q;
    last_d  = last_q;

    unique case (fsm_q)
      FILL: begin
        // Snapshot the register as it stands, not the value being computed.
        pool_d  = state_q;
        count_d = COUNT_W'(POOL_BYTES);
        fsm_d   = SERVE;
      end

      SERVE: begin
        if (count_q == '0) begin
          // Unreachable in normal operation; recover by refilling.
          fsm_d = FILL;
        end else if (elig0 | elig1) begin
          gnt0_d  = ~pick1;
          gnt1_d  =  pick1;
          rdata_d = pool_q[7:0] & (pick1 ? mask1 : mask0);
          pool_d  = pool_q >> 8;
          count_d = count_q - COUNT_W'(1);
          last_d  = pick1;
          if (count_q == COUNT_W'(1)) begin
            fsm_d = FILL;
          end
        end
      end

      default: fsm_d = FILL;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers (FSM, datapath and registered outputs together)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every flop samples the values
    // from before this edge regardless of statement order.
    if (reset) begin
      // NOTE: the byte pool is a plain register, not a memory array, so it is
      // cleared along with everything else; reset wins over all inputs.
      state_q <= SEED;
      pool_q  <= '0;
      count_q <= '0;
      fsm_q   <= FILL;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pool_q  <= pool_d;
      count_q <= count_d;
      fsm_q   <= fsm_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign rdata = rdata_q;

endmodule : rand_server

// File: tb/tb_rand_server.sv
// ---------------------------------------------------------------------------
// tb_rand_server
//   Bench for rand_server. A behavioural model (generator value, byte queue,
//   round-robin bookkeeping) predicts the outputs every cycle; directed
//   scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_rand_server;
  import rand_server_pkg::*;

  localparam logic [31:0] SEED = 32'd42;

  logic       clk;
  logic       reset;
  logic       key_event;
  logic       req0;
  logic [7:0] mask0;
  logic       req1;
  logic [7:0] mask1;
  logic       gnt0;
  logic       gnt1;
  logic [7:0] rdata;

  rand_server #(.SEED(SEED)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_event (key_event),
    .req0      (req0),
    .mask0     (mask0),
    .req1      (req1),
    .mask1     (mask1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rdata     (rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no grant within cycle budget (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] xs(input logic [31:0] v);
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Behavioural model: bytes waiting to be served live in a queue; an empty
  // queue costs one cycle to refill from the generator value.
  // -------------------------------------------------------------------------
  logic [31:0] m_state;
  logic [7:0]  m_pool[$];
  bit          m_need_fill;
  bit          m_gnt0, m_gnt1;
  logic [7:0]  m_rdata;
  bit          m_last_was1;
  bit          m_valid = 1'b0;

  initial begin : model
    bit         e0, e1, g0, g1;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_state     = SEED;
        m_pool.delete();
        m_need_fill = 1'b1;
        m_gnt0      = 1'b0;
        m_gnt1      = 1'b0;
        m_rdata     = 8'h00;
        m_last_was1 = 1'b1;
        m_valid     = 1'b1;
      end else if (m_valid) begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_need_fill) begin
          for (int i = 0; i < 4; i++) m_pool.push_back(m_state[8*i +: 8]);
          m_need_fill = 1'b0;
        end else begin
          e0 = req0 && !m_gnt0;
          e1 = req1 && !m_gnt1;
          if (e0 && e1) begin
            if (m_last_was1) g0 = 1'b1; else g1 = 1'b1;
          end else begin
            g0 = e0;
            g1 = e1;
          end
          if (g0 || g1) begin
            b           = m_pool.pop_front();
            m_rdata     = b & (g0 ? mask0 : mask1);
            m_last_was1 = g1;
            if (m_pool.size() == 0) m_need_fill = 1'b1;
          end
        end
        m_gnt0  = g0;
        m_gnt1  = g1;
        m_state = xs(m_state);
        if (key_event) m_state = xs(m_state);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en && m_valid) begin
        check("cyc_gnt0",  gnt0,  m_gnt0);
        check("cyc_gnt1",  gnt1,  m_gnt1);
        check("cyc_rdata", rdata, m_rdata);
        check("cyc_state", dut.state_q, m_state);
        if (gnt0 && gnt1) check("cyc_onehot", {gnt0, gnt1}, 2'b00);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Directed helpers
  // -------------------------------------------------------------------------
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_gnt(input int port, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((port == 0 && gnt0) || (port == 1 && gnt1)) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct packed {
    logic       r0;
    logic       r1;
    logic       key;
    logic [7:0] m0;
    logic [7:0] m1;
  } vec_t;

  // Mixed traffic: single-cycle requests dropped during FILL, stirs while
  // serving, lone and simultaneous requesters with differing masks.
  vec_t vecs[12] = '{
    '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hF0},
    '{1'b1, 1'b0, 1'b1, 8'h3C, 8'hF0},
    '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h0F},
    '{1'b1, 1'b1, 1'b0, 8'hAA, 8'h55},
    '{1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF},
    '{1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF},
    '{1'b1, 1'b0, 1'b0, 8'h81, 8'hFF},
    '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h7E},
    '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hC3},
    '{1'b1, 1'b1, 1'b0, 8'h0F, 8'hF0},
    '{1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF},
    '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h99}
  };

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  initial begin : main
    bit ok;
    bit g0_log[16];
    bit g1_log[16];
    bit any_both;
    int first;

    reset = 1'b1; key_event = 1'b0;
    req0 = 1'b0; mask0 = 8'h00; req1 = 1'b0; mask1 = 8'h00;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Reset state.
    check("rst_gnt0",  gnt0, 1'b0);
    check("rst_gnt1",  gnt1, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_state", dut.state_q, 32'd42);
    check("rst_fsm",   32'(dut.fsm_q), 32'(FILL));

    // First pool: FILL, then grant of 0x2A with full mask.
    reset = 1'b0; req0 = 1'b1; mask0 = 8'hFF;
    @(negedge clk);
    check("fill_no_gnt", gnt0, 1'b0);
    check("one_step",    dut.state_q, 32'h00AD4528);
    @(negedge clk);
    check("first_gnt0",  gnt0, 1'b1);
    check("first_rdata", rdata, 8'h2A);
    req0 = 1'b0;

    // Masked bytes from the same pool, then refill.
    do_reset();
    req0 = 1'b1; mask0 = 8'h0F;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(0, 8, ok);
      if (!ok) fail_timeout("masked_gnt");
      else check($sformatf("masked_byte%0d", k), rdata, (k == 0) ? 8'h0A : 8'h00);
    end
    check("masked_refill_fsm", 32'(dut.fsm_q), 32'(FILL));
    @(negedge clk);
    check("masked_hold_rdata", rdata, 8'h00);
    req0 = 1'b0;

    // Both ports requesting continuously: alternating, port 0 first.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; mask0 = 8'hFF; mask1 = 8'hFF;
    any_both = 1'b0;
    first = -1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      g0_log[c] = gnt0;
      g1_log[c] = gnt1;
      if (gnt0 && gnt1) any_both = 1'b1;
      if (first < 0 && (gnt0 || gnt1)) first = c;
    end
    check("rr_never_both", any_both, 1'b0);
    if (first < 0 || first > 12) begin
      fail_timeout("rr_first");
    end else begin
      check("rr_first_port0", g0_log[first],     1'b1);
      check("rr_then_port1",  g1_log[first + 1], 1'b1);
      check("rr_then_port0",  g0_log[first + 2], 1'b1);
      check("rr_then_port1b", g1_log[first + 3], 1'b1);
    end

    // Reset landing on a gnt1 cycle.
    wait_gnt(1, 10, ok);
    if (!ok) begin
      fail_timeout("rst_in_gnt1");
    end else begin
      reset = 1'b1;
      @(negedge clk);
      check("rg_gnt1",  gnt1, 1'b0);
      check("rg_rdata", rdata, 8'h00);
      check("rg_fsm",   32'(dut.fsm_q), 32'(FILL));
      check("rg_state", dut.state_q, SEED);
      reset = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Stir during the fill cycle: two steps, then the byte stream follows.
    do_reset();
    req0 = 1'b1; mask0 = 8'hFF; key_event = 1'b1;
    @(negedge clk);
    key_event = 1'b0;
    check("key_double_step", dut.state_q, xs(xs(SEED)));
    repeat (20) @(negedge clk);
    req0 = 1'b0;

    // Mixed directed traffic, checked cycle by cycle against the model.
    do_reset();
    for (int pass = 0; pass < 3; pass++) begin
      for (int v = 0; v < 12; v++) begin
        req0 = vecs[v].r0; req1 = vecs[v].r1; key_event = vecs[v].key;
        mask0 = vecs[v].m0; mask1 = vecs[v].m1;
        @(negedge clk);
      end
    end
    req0 = 1'b0; req1 = 1'b0; key_event = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_rand_server
